ct_butterfly: RTL
=================

# ct_butterfly

Pipelined forward-NTT Cooley-Tukey butterfly for the Kyber datapath (q = 3329). It is the forward-direction counterpart of the inverse-NTT subtract/halve path. It accepts a coefficient pair (a, b) and twiddle w through a valid/ready handshake and produces a' = (a + w·b) mod q and b' = (a − w·b) mod q. A 3-stage pipeline sits between the coefficient-memory read port and the write-back port of the NTT controller.

## Interface
- TAG_W, 8, width of the opaque tag (write-back address) carried alongside each operand set
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block accepts operand set this cycle
- a_in  in  12  coefficient a, canonical [0, 3328]
- b_in  in  12  coefficient b, canonical [0, 3328]
- w_in  in  12  twiddle, canonical [0, 3328]
- tag_in  in  TAG_W  passed through unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- a_out  out  12  (a + w·b) mod 3329, canonical
- b_out  out  12  (a − w·b) mod 3329, canonical
- tag_out  out  TAG_W  tag of this result

## Operation
- Transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
- Pipeline enable: en = !out_valid || out_ready. All stage registers and valid bits advance only when en = 1. in_ready = en (combinational, no dependency on in_valid).
- Stage 1 (S1): p = w_in · b_in as a 24-bit unsigned product (max 3328² = 11 075 584 < 2²⁴). Register p, a, tag, v1 = in_valid.
- Stage 2 (S2): Barrett quotient t = (p · 5039) >> 24, with 5039 = floor(2²⁴/3329). Compute r0 = p − t·3329 (r0 lies in [0, 3·3329)). Register r0 (14 bits), a, tag, v2 = v1.
- Stage 3 (S3): r = r0 reduced by up to two conditional subtractions of 3329, giving r in [0, 3328].
  - s = a + r (13 bits); if s ≥ 3329 then s − 3329.
  - d = a − r (13-bit two's complement); if negative then d + 3329.
  - Register a_out = s, b_out = d, tag_out, out_valid = v2.
- Bubbles (v = 0) advance like data. Datapath registers of invalid stages may hold any value, but outputs must read zero while out_valid = 0 after reset until the first result.
- Out-of-range operands (> 3328) are not supported. The bench does not drive them.

## Timing
- Latency: 3 cycles from input transfer to out_valid with out_ready held high.
- Throughput: 1 result per cycle when out_ready = 1.
- Back-pressure: out_valid && !out_ready freezes all three stages and drives in_ready low the same cycle. At most 3 results are in flight. No loss and no duplication.
- Output stability: while out_valid && !out_ready, a_out, b_out and tag_out hold.
- Reset (async, any time including mid-stream): v1, v2 and out_valid go to 0 and a_out, b_out and tag_out go to 0 immediately. In-flight data is discarded. in_ready = 1 from the first cycle after reset deasserts.
- Simultaneous output transfer and input transfer in the same cycle is legal and keeps full throughput.

## Structure
- The shared constants include holds KYBER_Q = 3329, BARRETT_M = 5039, BARRETT_K = 24 and COEF_W = 12. The inverse-path modules use the same include.
- One sub-module: barrett_reduce24. It is the S2 quotient/remainder logic plus the S3 double correction, is combinational, and is instanced once. The S2/S3 pipeline register sits between its r0 output and its correction input, so the module exposes r0 and the corrected-r path separately.
- Add/sub modular correction stays inline in S3.

## Test plan
- a=1, b=1, w=17, tag=0x05 → after 3 cycles: a_out=18, b_out=3313, tag_out=0x05.
- a=3328, b=3328, w=3328 (w·b ≡ 1) → a_out=0, b_out=3327.
- a=100, b=2, w=1729 (w·b = 3458 ≡ 129) → a_out=229, b_out=3300.
- 4 back-to-back inputs with out_ready=0 for 5 cycles:
  - in_ready drops once 3 results are held.
  - The 4th input waits.
  - After out_ready=1, the 4 results emerge in order on consecutive cycles with matching tags.
- Reset asserted while 2 results are in flight → out_valid=0 and all outputs 0 asynchronously. No stale result appears after release.
- 10 000 random canonical (a, b, w) with random in_valid/out_ready → every result matches the reference model (a ± w·b mod 3329) in order.

Source files
------------

// File: rtl/ct_butterfly_pkg.sv
`default_nettype none
// =============================================================================
// Module      : ct_butterfly_pkg
// Description : Shared Kyber constants and datapath types for the NTT butterflies.
// Revision    : 1.0 - initial release
// =============================================================================
package ct_butterfly_pkg;

    localparam int COEF_W    = 12;
    localparam int KYBER_Q   = 3329;
    localparam int BARRETT_M = 5039;
    localparam int BARRETT_K = 24;
    localparam int PROD_W    = 2 * COEF_W;
    localparam int REM_W     = 14;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [REM_W-1:0]  rem_t;

endpackage
`default_nettype wire

// File: rtl/ct_butterfly_if.sv
`default_nettype none
// =============================================================================
// Module      : ct_butterfly_if
// Description : Operand/result valid-ready bundle of the forward NTT butterfly.
// Revision    : 1.0 - initial release
// =============================================================================
interface ct_butterfly_if #(
    parameter int TAG_W = 8
);
    import ct_butterfly_pkg::*;

    logic             in_valid;
    logic             in_ready;
    coef_t            a_in;
    coef_t            b_in;
    coef_t            w_in;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    coef_t            a_out;
    coef_t            b_out;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, a_in, b_in, w_in, tag_in, out_ready,
        input  in_ready, out_valid, a_out, b_out, tag_out
    );

    modport slave (
        input  in_valid, a_in, b_in, w_in, tag_in, out_ready,
        output in_ready, out_valid, a_out, b_out, tag_out
    );

endinterface
`default_nettype wire

// File: rtl/ct_butterfly_barrett_reduce24.sv
`default_nettype none
// =============================================================================
// Module      : barrett_reduce24
// Description : Barrett reduction of a 24-bit product mod 3329, split into the
//               quotient/remainder half and the final correction half.
// Revision    : 1.0 - initial release
// =============================================================================
module barrett_reduce24
    import ct_butterfly_pkg::*;
(
    input  prod_t i_p,
    output rem_t  o_r0,
    input  rem_t  i_r0,
    output coef_t o_r
);

    localparam int MUL_W = PROD_W + 13;

    logic [MUL_W-1:0] w_prod;
    logic [12:0]      w_t;
    prod_t            w_tq;
    prod_t            w_diff;
    rem_t             w_c1;
    rem_t             w_c2;

    // Floor-based quotient underestimates by at most one, so r0 stays below 2q.
    always_comb begin
        w_prod = MUL_W'(i_p) * MUL_W'(BARRETT_M);
        w_t    = 13'(w_prod >> BARRETT_K);
        w_tq   = PROD_W'(w_t) * PROD_W'(KYBER_Q);
        w_diff = i_p - w_tq;
        o_r0   = REM_W'(w_diff);
    end

    always_comb begin
        w_c1 = (i_r0 >= REM_W'(KYBER_Q)) ? (i_r0 - REM_W'(KYBER_Q)) : i_r0;
        w_c2 = (w_c1 >= REM_W'(KYBER_Q)) ? (w_c1 - REM_W'(KYBER_Q)) : w_c1;
        o_r  = COEF_W'(w_c2);
    end

endmodule
`default_nettype wire

// File: rtl/ct_butterfly.sv
`default_nettype none
// =============================================================================
// Module      : ct_butterfly
// Description : 3-stage Cooley-Tukey forward NTT butterfly, a' = a + w*b,
//               b' = a - w*b (mod 3329), with valid/ready flow control.
// Revision    : 1.0 - initial release
// =============================================================================
module ct_butterfly
    import ct_butterfly_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  wire         clk,
    input  wire         rst,
    ct_butterfly_if.slave bus
);

    logic             w_en;
    prod_t            w_p;
    rem_t             w_r0;
    coef_t            w_r;
    logic [12:0]      w_sum;
    logic [12:0]      w_dif;
    logic [12:0]      w_s;
    logic [12:0]      w_d;

    logic             r_v1;
    prod_t            r_p1;
    coef_t            r_a1;
    logic [TAG_W-1:0] r_tag1;

    logic             r_v2;
    rem_t             r_r0;
    coef_t            r_a2;
    logic [TAG_W-1:0] r_tag2;

    logic             r_out_valid;
    coef_t            r_a_out;
    coef_t            r_b_out;
    logic [TAG_W-1:0] r_tag_out;

    // Whole pipeline stalls only when a result is held unconsumed.
    assign w_en         = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_en;
    assign bus.out_valid = r_out_valid;
    assign bus.a_out    = r_a_out;
    assign bus.b_out    = r_b_out;
    assign bus.tag_out  = r_tag_out;

    assign w_p = prod_t'(bus.w_in) * prod_t'(bus.b_in);

    barrett_reduce24 u_barrett (
        .i_p  (r_p1),
        .o_r0 (w_r0),
        .i_r0 (r_r0),
        .o_r  (w_r)
    );

    always_comb begin
        w_sum = {1'b0, r_a2} + {1'b0, w_r};
        w_s   = (w_sum >= 13'(KYBER_Q)) ? (w_sum - 13'(KYBER_Q)) : w_sum;
        w_dif = {1'b0, r_a2} - {1'b0, w_r};
        w_d   = w_dif[12] ? (w_dif + 13'(KYBER_Q)) : w_dif;
    end

    // Data registers only load behind a valid bit, so outputs stay zero
    // after reset until the first real result reaches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1        <= 1'b0;
            r_p1        <= '0;
            r_a1        <= '0;
            r_tag1      <= '0;
            r_v2        <= 1'b0;
            r_r0        <= '0;
            r_a2        <= '0;
            r_tag2      <= '0;
            r_out_valid <= 1'b0;
            r_a_out     <= '0;
            r_b_out     <= '0;
            r_tag_out   <= '0;
        end else if (w_en) begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                r_p1   <= w_p;
                r_a1   <= bus.a_in;
                r_tag1 <= bus.tag_in;
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_r0   <= w_r0;
                r_a2   <= r_a1;
                r_tag2 <= r_tag1;
            end
            r_out_valid <= r_v2;
            if (r_v2) begin
                r_a_out   <= COEF_W'(w_s);
                r_b_out   <= COEF_W'(w_d);
                r_tag_out <= r_tag2;
            end
        end
    end

endmodule
`default_nettype wire
